alu_cmd_issue: RTL

Upstream issue stage for ALU_DESIGN. Accepts operand/command packets over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the ALU with a single-cycle CE pulse, then holds off for the command's result latency. Emits RES_VLD in the exact cycle the ALU's RES/flags are valid, so downstream capture needs no latency knowledge.

---
 rtl/alu_cmd_issue_if.sv | 37 +++
 rtl/alu_cmd_issue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue_if.sv
// Packet-side valid/ready bus into the ALU issue stage.
// Master drives a command packet, slave returns IN_READY.
interface alu_cmd_issue_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_OPA;
  logic [DW-1:0] IN_OPB;
  logic          IN_CIN;
  logic [CW-1:0] IN_CMD;
  logic          IN_MODE;
  logic [1:0]    IN_INP_VALID;

  modport master (
    output IN_VALID,
    output IN_OPA,
    output IN_OPB,
    output IN_CIN,
    output IN_CMD,
    output IN_MODE,
    output IN_INP_VALID,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID,
    input  IN_OPA,
    input  IN_OPB,
    input  IN_CIN,
    input  IN_CMD,
    input  IN_MODE,
    input  IN_INP_VALID,
    output IN_READY
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// ALU issue stage: packet FIFO, one-shot CE issue, latency-timed RES_VLD.
// Optional ALU_ISSUE_STATS_EN adds issue/stall/drop counters.
module alu_cmd_issue #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  alu_cmd_issue_if.slave         in_if,
  input  logic                   HOLD,
  input  logic                   FLUSH,
  output logic [DW-1:0]          OPA,
  output logic [DW-1:0]          OPB,
  output logic                   CIN,
  output logic [CW-1:0]          CMD,
  output logic                   MODE,
  output logic [1:0]             INP_VALID,
  output logic                   CE,
  output logic                   RES_VLD,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] COUNT
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]            ISSUED_CNT,
  output logic [15:0]            STALL_CNT,
  output logic [7:0]             DROP_CNT
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int MAXL = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int LW   = $clog2(MAXL + 1);

  localparam logic [CNTW-1:0] FULL  = CNTW'(DEPTH);
  localparam logic [LW-1:0]   L_ALU = LW'(ALU_LAT);
  localparam logic [LW-1:0]   L_MUL = LW'(MUL_LAT);
  localparam logic [CW-1:0]   C_MUL = CW'(9);
  localparam logic [CW-1:0]   C_SHM = CW'(10);

  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          cin;
    logic [CW-1:0] cmd;
    logic          mode;
    logic [1:0]    iv;
  } ent_t;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  ent_t          wr_ent;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CNTW-1:0] cnt;
  state_t        state;
  state_t        state_nx;
  logic [LW-1:0] lcnt;
  logic [LW-1:0] lcnt_nx;
  logic          push;
  logic          pop;
  logic          res_nx;
  logic          is_mul;
  logic          not_empty;

  assign in_if.IN_READY = (cnt != FULL);
  assign not_empty      = (cnt != '0);
  assign COUNT          = cnt;
  assign BUSY           = not_empty || (state == WAIT);

  assign push = in_if.IN_VALID && in_if.IN_READY && !FLUSH;

  assign wr_ent = '{
    opa:  in_if.IN_OPA,
    opb:  in_if.IN_OPB,
    cin:  in_if.IN_CIN,
    cmd:  in_if.IN_CMD,
    mode: in_if.IN_MODE,
    iv:   in_if.IN_INP_VALID
  };

  assign head   = mem[rd_ptr];
  assign is_mul = head.mode && ((head.cmd == C_MUL) || (head.cmd == C_SHM));

  // Storage carries no reset; occupancy lives in cnt and the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_comb begin
    state_nx = state;
    lcnt_nx  = lcnt;
    pop      = 1'b0;
    res_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (not_empty && !HOLD && !FLUSH) begin
          pop      = 1'b1;
          state_nx = WAIT;
          lcnt_nx  = is_mul ? L_MUL : L_ALU;
        end
      end
      WAIT: begin
        lcnt_nx = lcnt - LW'(1);
        if (lcnt == LW'(1)) begin
          res_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      lcnt      <= '0;
      CE        <= 1'b0;
      RES_VLD   <= 1'b0;
      INP_VALID <= 2'b00;
      OPA       <= '0;
      OPB       <= '0;
      CIN       <= 1'b0;
      CMD       <= '0;
      MODE      <= 1'b0;
    end else begin
      state     <= state_nx;
      lcnt      <= lcnt_nx;
      CE        <= pop;
      RES_VLD   <= res_nx;
      INP_VALID <= pop ? head.iv : 2'b00;
      if (pop) begin
        OPA  <= head.opa;
        OPB  <= head.opb;
        CIN  <= head.cin;
        CMD  <= head.cmd;
        MODE <= head.mode;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        FLUSH: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end
        (push && !pop): begin
          wr_ptr <= wr_ptr + AW'(1);
          cnt    <= cnt + CNTW'(1);
        end
        (pop && !push): begin
          rd_ptr <= rd_ptr + AW'(1);
          cnt    <= cnt - CNTW'(1);
        end
        (push && pop): begin
          wr_ptr <= wr_ptr + AW'(1);
          rd_ptr <= rd_ptr + AW'(1);
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic stall_ev;
  logic drop_ev;

  assign stall_ev = (state == IDLE) && not_empty && HOLD;
  assign drop_ev  = in_if.IN_VALID && !in_if.IN_READY;

  // Saturating counters; FLUSH intentionally leaves them alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ISSUED_CNT <= '0;
      STALL_CNT  <= '0;
      DROP_CNT   <= '0;
    end else begin
      if (CE && (ISSUED_CNT != 16'hFFFF)) begin
        ISSUED_CNT <= ISSUED_CNT + 16'd1;
      end
      if (stall_ev && (STALL_CNT != 16'hFFFF)) begin
        STALL_CNT <= STALL_CNT + 16'd1;
      end
      if (drop_ev && (DROP_CNT != 8'hFF)) begin
        DROP_CNT <= DROP_CNT + 8'd1;
      end
    end
  end
`endif

endmodule
